uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the loopback design: recovers 8N1 frames (8 data bits, LSB first, one stop bit, idle high) from the serial line `rx`. It oversamples the line against a baud strobe and presents each received byte through a ready/acknowledge handshake. It sits opposite the UART transmitter, sharing its baud-rate tick source and state-encoding include, and feeds the loopback interface logic.

## Interface
- `OVERSAMPLE`, default 16: `tick` pulses per bit period; power of two, range 8..32.
- `clock_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  oversampling strobe: OVERSAMPLE × baud, one `clock_50` cycle wide.
- `rx`  in  1  asynchronous serial input; idles high.
- `rd_ack`  in  1  consumer acknowledge; clears `rx_ready` and `overrun`.
- `dados_recepcao`  out  8  last received byte.
- `rx_ready`  out  1  byte available; held until `rd_ack`.
- `rx_busy`  out  1  high whenever the FSM is not idle.
- `frame_err`  out  1  stop bit of the last frame sampled low.
- `parity_err`  out  1  parity mismatch on the last frame; constant 0 without `UART_RX_PARITY_EN`.
- `overrun`  out  1  a frame completed while `rx_ready` was still high; sticky.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized signal `rx_s`.
- Tick counter `cnt` is log2(OVERSAMPLE) bits wide and wraps naturally. Bit counter `nbit` is 3 bits.
- All state transitions and counter updates occur only on cycles where `tick`=1. The exceptions are `reset` and the `rd_ack` effects.
- FSM states (3-bit encoding):
  - RX_ESTADO_IDLE: if `rx_s`=0 on a tick, set `cnt`←0 and go to START.
  - RX_ESTADO_START: when `cnt`=OVERSAMPLE/2−1, check `rx_s`.
    - If `rx_s`=0, set `cnt`←0 and `nbit`←0, and go to DATA. Sampling is now aligned to mid-bit.
    - If `rx_s`=1, treat the low pulse as a glitch and return to IDLE. No flags change.
  - RX_ESTADO_DATA: when `cnt`=OVERSAMPLE−1, shift `rx_s` into the MSB of shift register `sr` (right shift, so LSB-first bits land in order).
    - `nbit`=7 goes to PARITY (with the macro) or to STOP.
  - RX_ESTADO_PARITY (macro only): when `cnt`=OVERSAMPLE−1, latch `p_bad` = (^sr) ^ `rx_s`. Even parity is required. Go to STOP.
  - RX_ESTADO_STOP: when `cnt`=OVERSAMPLE−1, complete the frame and go to IDLE.
- Frame completion, all in one cycle:
  - `dados_recepcao`←`sr`.
  - `frame_err`←~`rx_s`.
  - `parity_err`←`p_bad`.
  - `overrun`←`overrun` | (`rx_ready` & ~`rd_ack`).
  - `rx_ready`←1.
  - A frame with a bad stop bit or bad parity is still delivered, with its error flag set.
- A `rd_ack` cycle without completion clears `rx_ready` and `overrun`. `frame_err` and `parity_err` are kept until the next completion.
- Completion and `rd_ack` in the same cycle: the new byte wins, `rx_ready` stays 1, and `overrun` is not set.
- `rd_ack` while `rx_ready`=0 has no effect.
- `rx_busy` = (state ≠ IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, `sr`=0, synchronizer flops 1.
- `reset` mid-frame aborts the frame on the next edge. No partial byte is delivered and no flag is set.
- The start edge is detected 2 `clock_50` cycles after `rx` falls (synchronizer), on the first tick after that.
- Each bit is sampled at mid-bit, OVERSAMPLE/2 ticks after its nominal start, with ±1 tick of jitter.
- `rx_ready` rises on the `clock_50` edge following the stop-bit sample tick. It is therefore high 0.5 bit period before the stop bit ends.
- A new start bit is accepted on the first tick in IDLE, so back-to-back frames need no idle gap.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 and the PARITY state exists.
  - `parity_err` is live.
  - Frame length is 11 bit periods.
- Not defined:
  - Frame is 8N1 and PARITY is never entered.
  - `parity_err` is tied to 0.
  - Frame length is 10 bit periods.
- The transmitter must be built with the same setting.

## Structure
- Shared include `estados_uart.v` gains the RX_ESTADO_IDLE/START/DATA/PARITY/STOP 3-bit encodings. The existing transmitter encodings stay untouched.
- One sub-module, `rx_sync`: 2-flop synchronizer with reset value 1, reused by any other async input.

## Test plan
- Send 0x55 with OVERSAMPLE=16 and 16 ticks/bit → `dados_recepcao`=0x55, `rx_ready`=1, `frame_err`=0. Then `rd_ack` → `rx_ready`=0.
- Drive `rx` low for 4 ticks, then high → FSM returns to IDLE, `rx_ready` stays 0, `rx_busy` pulses for ≤8 ticks.
- Send 0xA3 with the stop bit forced to 0 → `dados_recepcao`=0xA3, `frame_err`=1. The next clean frame, 0x3C, clears `frame_err`.
- Send 0x11 then 0x22 back-to-back with no `rd_ack` → `dados_recepcao`=0x22, `overrun`=1. Then `rd_ack` → `overrun`=0, `rx_ready`=0.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err`=0.
- Assert `reset` during data bit 4 of 0xFF → all outputs 0 next edge. The following frame, 0x81, is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared state encodings and helpers for the UART receiver.
// The transmitter keeps its own encodings; only the RX_ESTADO_* values live here.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_ESTADO_IDLE   = 3'd0,
    RX_ESTADO_START  = 3'd1,
    RX_ESTADO_DATA   = 3'd2,
    RX_ESTADO_PARITY = 3'd3,
    RX_ESTADO_STOP   = 3'd4
  } rx_estado_t;

  localparam logic SYNC_IDLE_LEVEL = 1'b1;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_bad(input logic [7:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, status flags and acknowledge.
interface uart_rx_if;
  logic       rd_ack;
  logic [7:0] dados_recepcao;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rd_ack,
    input  dados_recepcao, rx_ready, rx_busy, frame_err, parity_err, overrun
  );

  modport slave (
    input  rd_ack,
    output dados_recepcao, rx_ready, rx_busy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to RESET_VAL.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a live parity_err.
// Oversamples rx against tick and hands bytes over through the uart_rx_if ready/ack handshake.
//
// state            | meaning
// RX_ESTADO_IDLE   | line idle, waiting for rx_s low on a tick
// RX_ESTADO_START  | confirming start bit at its middle
// RX_ESTADO_DATA   | sampling 8 data bits at mid-bit, LSB first
// RX_ESTADO_PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// RX_ESTADO_STOP   | sampling the stop bit, then completing the frame
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic    clock_50,
  input  logic    reset,
  input  logic    tick,
  input  logic    rx,
  uart_rx_if.slave bus
);

  localparam int             CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  CNT_END = CW'(OVERSAMPLE - 1);

  logic          rx_s;
  rx_estado_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          done;
`ifdef UART_RX_PARITY_EN
  logic          p_bad_q, p_bad_d;
  logic          perr_q, perr_d;
`endif

  rx_sync #(.RESET_VAL(SYNC_IDLE_LEVEL)) u_rx_sync (
    .clk   (clock_50),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nbit_d  = nbit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_bad_d = p_bad_q;
    perr_d  = perr_q;
`endif

    if (tick) begin
      case (state_q)
        RX_ESTADO_IDLE: begin
          if (!rx_s) begin
            cnt_d   = '0;
            state_d = RX_ESTADO_START;
          end
        end
        RX_ESTADO_START: begin
          if (cnt_q == CNT_MID) begin
            if (!rx_s) begin
              cnt_d   = '0;
              nbit_d  = '0;
              state_d = RX_ESTADO_DATA;
            end else begin
              state_d = RX_ESTADO_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_ESTADO_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_END) begin
            sr_d   = {rx_s, sr_q[7:1]};
            nbit_d = nbit_q + 3'd1;
            if (nbit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_ESTADO_PARITY;
`else
              state_d = RX_ESTADO_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_ESTADO_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_END) begin
            p_bad_d = even_parity_bad(sr_q, rx_s);
            state_d = RX_ESTADO_STOP;
          end
        end
`endif
        RX_ESTADO_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_END) begin
            done    = 1'b1;
            state_d = RX_ESTADO_IDLE;
          end
        end
        default: state_d = RX_ESTADO_IDLE;
      endcase
    end

    // A completing frame outranks a simultaneous acknowledge.
    if (done) begin
      data_d  = sr_q;
      ferr_d  = ~rx_s;
      ovr_d   = ovr_q | (ready_q & ~bus.rd_ack);
      ready_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_d  = p_bad_q;
`endif
    end else if (bus.rd_ack && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= RX_ESTADO_IDLE;
      cnt_q   <= '0;
      nbit_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_bad_q <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbit_q  <= nbit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      p_bad_q <= p_bad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dados_recepcao = data_q;
  assign bus.rx_ready       = ready_q;
  assign bus.rx_busy        = (state_q != RX_ESTADO_IDLE);
  assign bus.frame_err      = ferr_q;
  assign bus.overrun        = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err     = perr_q;
`else
  assign bus.parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model of the handshake outputs checked every quiet cycle,
// plus literal expectations for each scenario. Honours UART_RX_PARITY_EN like the DUT.
module tb_uart_rx;

  localparam int OS = 16;

  logic clock_50 = 1'b0;
  logic reset    = 1'b1;
  logic tick     = 1'b0;
  logic rx       = 1'b1;

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .tick     (tick),
    .rx       (rx),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  // One tick every third clock, settled well before the sampling negedge.
  int tdiv = 0;
  always @(posedge clock_50) begin
    #1;
    tdiv = (tdiv == 2) ? 0 : tdiv + 1;
    tick = (tdiv == 0);
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data;
  logic       exp_ready, exp_ferr, exp_perr, exp_ovr;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock_50) begin
    if (chk_en) begin
      chk("model_data",   bus.dados_recepcao, exp_data);
      chk("model_ready",  bus.rx_ready,       exp_ready);
      chk("model_ferr",   bus.frame_err,      exp_ferr);
      chk("model_perr",   bus.parity_err,     exp_perr);
      chk("model_ovr",    bus.overrun,        exp_ovr);
    end
  end

  int busy_ticks = 0;
  bit cnt_busy   = 1'b0;
  always @(negedge clock_50) begin
    if (cnt_busy && tick && bus.rx_busy) busy_ticks++;
  end

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    exp_ferr  = 1'b0;
    exp_perr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic model_complete(input logic [7:0] d, input logic stop, input logic pbit);
    exp_ovr   = exp_ovr | exp_ready;
    exp_data  = d;
    exp_ferr  = !stop;
`ifdef UART_RX_PARITY_EN
    exp_perr  = ^{d, pbit};
`else
    exp_perr  = 1'b0 & pbit;
`endif
    exp_ready = 1'b1;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clock_50);
    while (!tick && n < 10) begin
      @(negedge clock_50);
      n++;
    end
    if (!tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) wait_tick();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (i == 3) chk("busy_mid_frame", bus.rx_busy, 1);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit);
`endif
    rx = stop;
    repeat (3) wait_tick();
    chk_en = 1'b0;
    repeat (10) wait_tick();
    model_complete(d, stop, pbit);
    chk_en = 1'b1;
    repeat (3) wait_tick();
  endtask

  task automatic ack();
    chk_en = 1'b0;
    bus.rd_ack = 1'b1;
    @(negedge clock_50);
    bus.rd_ack = 1'b0;
    if (exp_ready) begin
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end
    @(negedge clock_50);
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_ack = 1'b0;
    model_reset();
    repeat (4) @(negedge clock_50);
    chk("rst_data",  bus.dados_recepcao, 8'h00);
    chk("rst_ready", bus.rx_ready, 0);
    chk("rst_busy",  bus.rx_busy, 0);
    chk("rst_ferr",  bus.frame_err, 0);
    chk("rst_perr",  bus.parity_err, 0);
    chk("rst_ovr",   bus.overrun, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(20);

    // 0x55 clean frame, then acknowledge
    send_frame(8'h55, 1'b1, 1'b0);
    chk("b55_data",  bus.dados_recepcao, 8'h55);
    chk("b55_ready", bus.rx_ready, 1);
    chk("b55_ferr",  bus.frame_err, 0);
    chk("b55_perr",  bus.parity_err, 0);
    ack();
    chk("b55_ack_ready", bus.rx_ready, 0);
    idle(8);

    // short low glitch
    busy_ticks = 0;
    cnt_busy = 1'b1;
    rx = 1'b0;
    repeat (4) wait_tick();
    rx = 1'b1;
    repeat (20) wait_tick();
    cnt_busy = 1'b0;
    chk("glitch_busy_seen", busy_ticks > 0, 1);
    chk("glitch_busy_le8",  busy_ticks <= 8, 1);
    chk("glitch_idle",      bus.rx_busy, 0);
    chk("glitch_ready",     bus.rx_ready, 0);
    idle(8);

    // 0xA3 with stop bit low
    send_frame(8'hA3, 1'b0, 1'b0);
    chk("a3_data", bus.dados_recepcao, 8'hA3);
    chk("a3_ferr", bus.frame_err, 1);
    chk("a3_ready", bus.rx_ready, 1);
    idle(32);
    ack();
    chk("a3_ack_ferr_kept", bus.frame_err, 1);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("3c_data", bus.dados_recepcao, 8'h3C);
    chk("3c_ferr", bus.frame_err, 0);
    chk("3c_ovr",  bus.overrun, 0);
    ack();
    idle(8);

    // back-to-back without acknowledge
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("b2b_data",  bus.dados_recepcao, 8'h22);
    chk("b2b_ovr",   bus.overrun, 1);
    chk("b2b_ready", bus.rx_ready, 1);
    ack();
    chk("b2b_ack_ovr",   bus.overrun, 0);
    chk("b2b_ack_ready", bus.rx_ready, 0);
    idle(8);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par0_perr", bus.parity_err, 1);
    chk("par0_data", bus.dados_recepcao, 8'h07);
    ack();
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par1_perr", bus.parity_err, 0);
    ack();
    idle(8);
`endif

    // reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) wait_tick();
    chk("pre_reset_busy", bus.rx_busy, 1);
    chk_en = 1'b0;
    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_data",  bus.dados_recepcao, 8'h00);
    chk("mid_rst_ready", bus.rx_ready, 0);
    chk("mid_rst_busy",  bus.rx_busy, 0);
    chk("mid_rst_ferr",  bus.frame_err, 0);
    chk("mid_rst_ovr",   bus.overrun, 0);
    idle(40);
    chk_en = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    chk("b81_data",  bus.dados_recepcao, 8'h81);
    chk("b81_ready", bus.rx_ready, 1);
    chk("b81_ferr",  bus.frame_err, 0);
    ack();
    idle(8);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
